// File: rtl/mac_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mac_operand_sequencer
//
// Upstream feeder for the 64-bit pipelined MAC in the MAC VFU. Operand
// triples (m1, m2, addend) are buffered in a small FIFO and issued one at a
// time to the MAC get_values method. Each 128-bit result is captured at the
// MAC's fixed latency and presented in order on a valid/ready output, tagged
// with a wrapping sequence index.
//
// The MAC produces no new result when a triple is identical to the one it
// last accepted. Such triples are never issued; the held result is replayed
// on the output instead.
//
// Build option:
//   MAC_SEQ_WATCHDOG_EN  - when defined, a watchdog abandons a result that
//                          has not arrived after 16 cycles in CAPT. The
//                          output then reports out_err=1 with out_data=0.
//                          When undefined, CAPT waits indefinitely and
//                          out_err is tied to 0.
//
// Parameters:
//   DEPTH    operand FIFO entries (power of 2, >= 2)
//   MAC_LAT  cycles from mac_en to a valid mac_result
//   IDX_W    width of the result sequence index
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   in_valid/in_ready             operand triple handshake
//   in_m1/in_m2/in_addend         operand triple (64 bits each)
//   mac_en/mac_rdy                MAC EN_get_values / RDY_get_values
//   mac_m1/mac_m2/mac_addend      MAC get_values_* operands (held between issues)
//   mac_res_en/mac_res_rdy        MAC EN_mac_result / RDY_mac_result
//   mac_result                    MAC 128-bit result
//   out_valid/out_ready           result handshake
//   out_data                      result (m1*m2+addend, full 128 bits)
//   out_idx                       sequence number of the result, wraps
//   out_err                       result abandoned by the watchdog
//   busy                          FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module mac_operand_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAC_LAT = 3,
    parameter int unsigned IDX_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_m1,
    input  logic [63:0]        in_m2,
    input  logic [63:0]        in_addend,

    output logic               mac_en,
    input  logic               mac_rdy,
    output logic [63:0]        mac_m1,
    output logic [63:0]        mac_m2,
    output logic [63:0]        mac_addend,

    output logic               mac_res_en,
    input  logic [127:0]       mac_result,
    input  logic               mac_res_rdy,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned TW  = 192;
    localparam int unsigned WCW = (MAC_LAT > 2) ? $clog2(MAC_LAT) : 1;

    // WAIT lasts MAC_LAT-1 cycles so that CAPT lands exactly MAC_LAT cycles
    // after the mac_en cycle.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((MAC_LAT >= 2) ? MAC_LAT - 2 : 0);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    // -----------------------------------------------------------------------
    // Operand FIFO
    // -----------------------------------------------------------------------
    logic [TW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [TW-1:0] head;

    assign fifo_empty = (count == '0);
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_m1, in_m2, in_addend};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Last-issued triple (L) and held result (H)
    // -----------------------------------------------------------------------
    // l_valid=0 marks L as matching nothing; it starts set because the MAC
    // resets with 0,0,0 registered and a 0 result.
    logic [TW-1:0]  l_trip;
    logic           l_valid;
    logic [127:0]   h_res;
    logic           head_match;

    assign head_match = l_valid && (head == l_trip);

    // -----------------------------------------------------------------------
    // Latency counter and optional watchdog
    // -----------------------------------------------------------------------
    logic [WCW-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RST || state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

`ifdef MAC_SEQ_WATCHDOG_EN
    logic [4:0] wd_cnt;
    logic       wd_fire;
    logic       err_q;

    // Counts consecutive CAPT cycles without mac_res_rdy; the 16th such
    // cycle sees wd_cnt == 15 and gives up on the result.
    always_ff @(posedge CLK) begin
        if (RST || state != S_CAPT) begin
            wd_cnt <= '0;
        end else if (!mac_res_rdy) begin
            wd_cnt <= wd_cnt + 5'd1;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    logic load_mac;
    logic issue;
    logic capture;
    logic replay;
    logic deliver;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        load_mac   = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        replay     = 1'b0;
        deliver    = 1'b0;
        mac_en     = 1'b0;
        mac_res_en = 1'b0;
        out_valid  = 1'b0;
`ifdef MAC_SEQ_WATCHDOG_EN
        wd_fire    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_match) begin
                        // MAC would suppress this triple; reuse H.
                        replay    = 1'b1;
                        state_nxt = S_OUT;
                    end else begin
                        load_mac  = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mac_rdy) begin
                    mac_en    = 1'b1;
                    issue     = 1'b1;
                    state_nxt = (MAC_LAT > 1) ? S_WAIT : S_CAPT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                if (mac_res_rdy) begin
                    mac_res_en = 1'b1;
                    capture    = 1'b1;
                    state_nxt  = S_OUT;
                end
`ifdef MAC_SEQ_WATCHDOG_EN
                else if (wd_cnt == 5'd15) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_OUT;
                end
`endif
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    deliver   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            mac_m1     <= '0;
            mac_m2     <= '0;
            mac_addend <= '0;
            l_trip     <= '0;
            l_valid    <= 1'b1;
            h_res      <= '0;
            out_data   <= '0;
            out_idx    <= '0;
        end else begin
            if (load_mac) begin
                {mac_m1, mac_m2, mac_addend} <= head;
            end
            if (issue) begin
                l_trip  <= {mac_m1, mac_m2, mac_addend};
                l_valid <= 1'b1;
            end
            if (capture) begin
                h_res    <= mac_result;
                out_data <= mac_result;
            end
            if (replay) begin
                out_data <= h_res;
            end
            if (deliver) begin
                out_idx <= out_idx + IDX_W'(1);
            end
`ifdef MAC_SEQ_WATCHDOG_EN
            // The MAC state is unknown after a lost result, so the next
            // triple must issue even if it equals the last one.
            if (wd_fire) begin
                out_data <= '0;
                l_valid  <= 1'b0;
            end
`endif
        end
    end

`ifdef MAC_SEQ_WATCHDOG_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (wd_fire) begin
            err_q <= 1'b1;
        end else if (capture || replay) begin
            err_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAC_LAT = 3;
    localparam int unsigned IDX_W   = 8;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [63:0]        in_m1 = '0;
    logic [63:0]        in_m2 = '0;
    logic [63:0]        in_addend = '0;
    logic               mac_en;
    logic               mac_rdy = 1'b1;
    logic [63:0]        mac_m1;
    logic [63:0]        mac_m2;
    logic [63:0]        mac_addend;
    logic               mac_res_en;
    logic [127:0]       mac_result;
    logic               mac_res_rdy = 1'b1;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [127:0]       out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_err;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int unsigned n_mac_en = 0;
    int unsigned n_res_en = 0;

    // MAC stand-in: three-stage result pipeline, result holds between issues
    logic [127:0] mac_p1 = '0;
    logic [127:0] mac_p2 = '0;
    logic [127:0] mac_p3 = '0;

    always #5 CLK = ~CLK;

    mac_operand_sequencer #(
        .DEPTH   (DEPTH),
        .MAC_LAT (MAC_LAT),
        .IDX_W   (IDX_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_m1       (in_m1),
        .in_m2       (in_m2),
        .in_addend   (in_addend),
        .mac_en      (mac_en),
        .mac_rdy     (mac_rdy),
        .mac_m1      (mac_m1),
        .mac_m2      (mac_m2),
        .mac_addend  (mac_addend),
        .mac_res_en  (mac_res_en),
        .mac_result  (mac_result),
        .mac_res_rdy (mac_res_rdy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_err     (out_err),
        .busy        (busy)
    );

    always @(posedge CLK) begin
        if (mac_en) mac_p1 <= {64'd0, mac_m1} * {64'd0, mac_m2} + {64'd0, mac_addend};
        mac_p2 <= mac_p1;
        mac_p3 <= mac_p2;
        if (mac_en) n_mac_en <= n_mac_en + 1;
        if (mac_res_en) n_res_en <= n_res_en + 1;
    end
    assign mac_result = mac_p3;

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0; mac_rdy = 1'b1; mac_res_rdy = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL reset_mac_en: got %b expected 0", mac_en); end
        checks++; if (mac_res_en !== 1'b0) begin errors++; $display("FAIL reset_mac_res_en: got %b expected 0", mac_res_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({mac_m1, mac_m2, mac_addend} !== 192'd0) begin errors++; $display("FAIL reset_mac_ops: got %h expected 0", {mac_m1, mac_m2, mac_addend}); end
        checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_idx !== 8'd0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
        RST = 1'b0;
    endtask

    task automatic test_replay_zero();
        int unsigned en0;
        do_reset();
        en0 = n_mac_en;
        in_m1 = 64'd0; in_m2 = 64'd0; in_addend = 64'd0; in_valid = 1'b1;   // cycle A
        @(negedge CLK); in_valid = 1'b0;                                     // A+1
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL replay0_valid_A1: got %b expected 0", out_valid); end
        @(negedge CLK);                                                      // A+2
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL replay0_valid_A2: got %b expected 1", out_valid); end
        checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL replay0_data: got %h expected 0", out_data); end
        checks++; if (out_idx !== 8'd0) begin errors++; $display("FAIL replay0_idx: got %0d expected 0", out_idx); end
        @(negedge CLK);                                                      // A+3
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL replay0_valid_A3: got %b expected 0", out_valid); end
        checks++; if (out_idx !== 8'd1) begin errors++; $display("FAIL replay0_idx_after: got %0d expected 1", out_idx); end
        checks++; if (n_mac_en - en0 !== 0) begin errors++; $display("FAIL replay0_no_mac_en: got %0d pulses expected 0", n_mac_en - en0); end
    endtask

    task automatic test_single_issue();
        int unsigned r0;
        do_reset();
        r0 = n_res_en;
        in_m1 = 64'd3; in_m2 = 64'd5; in_addend = 64'd7; in_valid = 1'b1;  // A
        @(negedge CLK); in_valid = 1'b0;                                     // A+1
        checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL single_mac_en_A1: got %b expected 0", mac_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_A1: got %b expected 1", busy); end
        @(negedge CLK);                                                      // A+2
        checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL single_mac_en_A2: got %b expected 1", mac_en); end
        checks++; if ({mac_m1, mac_m2, mac_addend} !== {64'd3, 64'd5, 64'd7}) begin errors++; $display("FAIL single_mac_ops: got %0d,%0d,%0d expected 3,5,7", mac_m1, mac_m2, mac_addend); end
        @(negedge CLK);                                                      // A+3
        checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL single_mac_en_A3: got %b expected 0", mac_en); end
        @(negedge CLK);                                                      // A+4
        checks++; if (mac_res_en !== 1'b0) begin errors++; $display("FAIL single_res_en_A4: got %b expected 0", mac_res_en); end
        @(negedge CLK);                                                      // A+5
        checks++; if (mac_res_en !== 1'b1) begin errors++; $display("FAIL single_res_en_A5: got %b expected 1", mac_res_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_A5: got %b expected 0", out_valid); end
        @(negedge CLK);                                                      // A+6
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_A6: got %b expected 1", out_valid); end
        checks++; if (out_data !== 128'd22) begin errors++; $display("FAIL single_data: got %0d expected 22", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", out_err); end
        @(negedge CLK);                                                      // A+7
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_A7: got busy=%b valid=%b expected 0,0", busy, out_valid); end
        checks++; if (n_res_en - r0 !== 1) begin errors++; $display("FAIL single_res_en_count: got %0d expected 1", n_res_en - r0); end
    endtask

    task automatic test_max_operands();
        do_reset();
        in_m1 = '1; in_m2 = '1; in_addend = '1; in_valid = 1'b1;
        @(negedge CLK); in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) break;
            @(negedge CLK);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_timeout: got out_valid=%b expected 1 within 20 cycles", out_valid); end
        checks++; if (out_data !== 128'hFFFFFFFFFFFFFFFF0000000000000000) begin errors++; $display("FAIL max_data: got %h expected ffffffffffffffff0000000000000000", out_data); end
    endtask

    task automatic test_back_to_back();
        int unsigned en0;
        logic [127:0] dq[$];
        logic [IDX_W-1:0] iq[$];
        logic [127:0] exp_d [3];
        exp_d[0] = 128'd22; exp_d[1] = 128'd22; exp_d[2] = 128'd23;
        do_reset();
        en0 = n_mac_en;
        in_m1 = 64'd3; in_m2 = 64'd5; in_addend = 64'd7; in_valid = 1'b1;  // A
        @(negedge CLK);                                                      // A+1, same triple
        @(negedge CLK); in_addend = 64'd8;                                   // A+2
        @(negedge CLK); in_valid = 1'b0;
        for (int c = 0; c < 60 && dq.size() < 3; c++) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin dq.push_back(out_data); iq.push_back(out_idx); end
            @(negedge CLK);
        end
        checks++; if (dq.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d results expected 3", dq.size()); end
        else begin
            for (int unsigned i = 0; i < 3; i++) begin
                checks++; if (dq[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data_%0d: got %0d expected %0d", i, dq[i], exp_d[i]); end
                checks++; if (iq[i] !== IDX_W'(i)) begin errors++; $display("FAIL b2b_idx_%0d: got %0d expected %0d", i, iq[i], i); end
            end
        end
        checks++; if (n_mac_en - en0 !== 2) begin errors++; $display("FAIL b2b_mac_en_pulses: got %0d expected 2", n_mac_en - en0); end
    endtask

    task automatic test_backpressure();
        int unsigned en0;
        logic taken;
        logic [127:0] dq[$];
        logic [IDX_W-1:0] iq[$];
        logic [127:0] exp_d [6];
        exp_d[0] = 128'd2;  exp_d[1] = 128'd5;  exp_d[2] = 128'd8;
        exp_d[3] = 128'd11; exp_d[4] = 128'd14; exp_d[5] = 128'd17;
        do_reset();
        en0 = n_mac_en;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_m1 = 64'(i + 1); in_m2 = 64'd2; in_addend = 64'(i); in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before_full_%0d: got %b expected 1", i, in_ready); end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        repeat (3) @(negedge CLK);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 128'd2) begin errors++; $display("FAIL bp_hold: got ready=%b valid=%b data=%0d expected 0,1,2", in_ready, out_valid, out_data); end
        in_m1 = 64'd6; in_m2 = 64'd2; in_addend = 64'd5; in_valid = 1'b1;
        out_ready = 1'b1;
        taken = 1'b0;
        for (int c = 0; c < 200 && dq.size() < 6; c++) begin
            if (taken) in_valid = 1'b0;
            if (out_valid === 1'b1) begin dq.push_back(out_data); iq.push_back(out_idx); end
            taken = in_valid && in_ready;
            @(negedge CLK);
        end
        in_valid = 1'b0;
        checks++; if (dq.size() != 6) begin errors++; $display("FAIL bp_count: got %0d results expected 6", dq.size()); end
        else begin
            for (int unsigned i = 0; i < 6; i++) begin
                checks++; if (dq[i] !== exp_d[i]) begin errors++; $display("FAIL bp_data_%0d: got %0d expected %0d", i, dq[i], exp_d[i]); end
                checks++; if (iq[i] !== IDX_W'(i)) begin errors++; $display("FAIL bp_idx_%0d: got %0d expected %0d", i, iq[i], i); end
            end
        end
        checks++; if (n_mac_en - en0 !== 6) begin errors++; $display("FAIL bp_mac_en_pulses: got %0d expected 6", n_mac_en - en0); end
    endtask

    task automatic test_reset_in_wait();
        int unsigned en0, r0, bad;
        do_reset();
        en0 = n_mac_en; r0 = n_res_en; bad = 0;
        in_m1 = 64'd3; in_m2 = 64'd5; in_addend = 64'd7; in_valid = 1'b1;  // A
        @(negedge CLK); in_valid = 1'b0;                                     // A+1
        repeat (2) @(negedge CLK);                                           // A+3, WAIT
        checks++; if (busy !== 1'b1 || n_mac_en - en0 !== 1) begin errors++; $display("FAIL rstwait_pre: got busy=%b pulses=%0d expected 1,1", busy, n_mac_en - en0); end
        RST = 1'b1;
        @(negedge CLK);                                                      // A+4
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstwait_after: got busy=%b valid=%b expected 0,0", busy, out_valid); end
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (out_valid !== 1'b0 || busy !== 1'b0 || mac_res_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstwait_quiet: got %0d active cycles expected 0", bad); end
        checks++; if (n_res_en - r0 !== 0 || n_mac_en - en0 !== 1) begin errors++; $display("FAIL rstwait_pulses: got res_en=%0d mac_en=%0d expected 0,1", n_res_en - r0, n_mac_en - en0); end
    endtask

    task automatic test_issue_stall();
        int unsigned bad;
        do_reset();
        bad = 0;
        mac_rdy = 1'b0;
        in_m1 = 64'd3; in_m2 = 64'd5; in_addend = 64'd8; in_valid = 1'b1;  // A
        @(negedge CLK); in_valid = 1'b0;                                     // A+1
        for (int c = 0; c < 3; c++) begin                                    // A+2..A+4
            @(negedge CLK);
            if (mac_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL istall_no_en: got %0d mac_en cycles expected 0", bad); end
        mac_rdy = 1'b1;
        #1;
        checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL istall_en: got %b expected 1", mac_en); end
        @(negedge CLK);
        checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL istall_single_pulse: got %b expected 0", mac_en); end
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) break;
            @(negedge CLK);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 128'd23) begin errors++; $display("FAIL istall_result: got valid=%b data=%0d expected 1,23", out_valid, out_data); end
    endtask

    task automatic test_capt_stall();
        int unsigned bad, r0;
`ifdef MAC_SEQ_WATCHDOG_EN
        int unsigned en1;
`endif
        do_reset();
        bad = 0; r0 = n_res_en;
        mac_res_rdy = 1'b0;
        in_m1 = 64'd3; in_m2 = 64'd5; in_addend = 64'd7; in_valid = 1'b1;  // A
        @(negedge CLK); in_valid = 1'b0;                                     // A+1
        repeat (4) @(negedge CLK);                                           // A+5, CAPT cycle 1
`ifdef MAC_SEQ_WATCHDOG_EN
        for (int c = 0; c < 16; c++) begin                                   // CAPT cycles 1..16
            if (out_valid !== 1'b0 || mac_res_en !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wd_early: got %0d early cycles expected 0", bad); end
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++; $display("FAIL wd_fire: got valid=%b err=%b expected 1,1", out_valid, out_err); end
        checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL wd_data: got %0d expected 0", out_data); end
        checks++; if (n_res_en - r0 !== 0) begin errors++; $display("FAIL wd_res_en: got %0d expected 0", n_res_en - r0); end
        mac_res_rdy = 1'b1;
        @(negedge CLK);
        en1 = n_mac_en;
        in_m1 = 64'd3; in_m2 = 64'd5; in_addend = 64'd7; in_valid = 1'b1;
        @(negedge CLK); in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) break;
            @(negedge CLK);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 128'd22 || out_err !== 1'b0) begin errors++; $display("FAIL wd_reissue: got valid=%b data=%0d err=%b expected 1,22,0", out_valid, out_data, out_err); end
        checks++; if (n_mac_en - en1 !== 1) begin errors++; $display("FAIL wd_reissue_en: got %0d expected 1", n_mac_en - en1); end
`else
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b0 || busy !== 1'b1 || mac_res_en !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL capt_wait: got %0d cycles leaving CAPT expected 0", bad); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL capt_err: got %b expected 0", out_err); end
        mac_res_rdy = 1'b1;
        #1;
        checks++; if (mac_res_en !== 1'b1) begin errors++; $display("FAIL capt_res_en: got %b expected 1", mac_res_en); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1 || out_data !== 128'd22) begin errors++; $display("FAIL capt_result: got valid=%b data=%0d expected 1,22", out_valid, out_data); end
        checks++; if (n_res_en - r0 !== 1) begin errors++; $display("FAIL capt_res_en_count: got %0d expected 1", n_res_en - r0); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within 500000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_replay_zero();
        test_single_issue();
        test_max_operands();
        test_back_to_back();
        test_backpressure();
        test_reset_in_wait();
        test_issue_stall();
        test_capt_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Upstream feeder for the 64-bit pipelined MAC unit in the MAC VFU. It buffers operand triples (multiplicand1, multiplicand2, addend) from the vector operand path and issues them one at a time to the MAC's `get_values` method. It captures each 128-bit result at the MAC's fixed latency and presents results in order, each with a sequence index, on a valid/ready output. It also resolves the MAC's duplicate-operand suppression: the MAC produces no new result for a triple identical to the previous one, so this block replays the held result instead of issuing.

## Interface
Reset is RST, synchronous, active-high; clock is CLK.

Parameters:
- DEPTH, 4: operand FIFO entries (power of 2, ≥2)
- MAC_LAT, 3: cycles from `mac_en` to a valid `mac_result`
- IDX_W, 8: width of the result sequence index

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- in_valid  in  1  operand triple offered
- in_ready  out  1  FIFO not full
- in_m1, in_m2, in_addend  in  64 each  operand triple
- mac_en  out  1  drives MAC EN_get_values
- mac_rdy  in  1  MAC RDY_get_values
- mac_m1, mac_m2, mac_addend  out  64 each  drive the MAC get_values_* inputs
- mac_res_en  out  1  drives MAC EN_mac_result
- mac_result  in  128  MAC result
- mac_res_rdy  in  1  MAC RDY_mac_result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  128  result, m1*m2+addend
- out_idx  out  IDX_W  sequence number of this result, wraps modulo 2^IDX_W
- out_err  out  1  result invalid (watchdog); 0 when the watchdog is compiled out
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- FIFO: push when in_valid && in_ready; in_ready = !full, from registered count. Pop occurs on leaving IDLE.
- Block state: last triple L, initial value 0,0,0. Held result H, initial value 0. Both match the MAC's reset registers, since 0*0+0=0.
- FSM states: IDLE, ISSUE, WAIT, CAPT, OUT.
- IDLE:
  - FIFO non-empty and head ≠ L: pop, latch head into mac_* regs, go to ISSUE.
  - FIFO non-empty and head == L: pop, go to OUT with out_data=H (replay, MAC untouched).
  - FIFO empty: stay in IDLE.
- ISSUE:
  - mac_en=1 for exactly one cycle when mac_rdy=1; L ← issued triple; go to WAIT.
  - If mac_rdy=0, hold in ISSUE.
- WAIT: count MAC_LAT−1 cycles, then go to CAPT.
- CAPT:
  - If mac_res_rdy=1: H ← mac_result, pulse mac_res_en one cycle, go to OUT.
  - Else stay in CAPT.
- OUT: out_valid=1; out_data, out_idx, out_err held stable until out_ready. On handshake, out_idx increments and the FSM returns to IDLE.
- mac_m1/m2/addend are held stable between issues.
- Width rule: no arithmetic in this block; out_data is the MAC's full 128-bit result, no truncation.
- Reset values:
  - in_ready=1; mac_en=0; mac_res_en=0; out_valid=0; out_err=0; busy=0.
  - mac_* = 0; out_data=0; out_idx=0.
  - FIFO empty; L=0,0,0; H=0; state IDLE.
- Reset mid-operation (any state) discards FIFO contents and any in-flight result; no mac_en or mac_res_en pulse follows. The MAC shares RST, so L=0 stays consistent with it.

## Timing
- Push at cycle A into an empty FIFO with an idle FSM:
  - IDLE decision at A+1.
  - mac_en at T=A+2.
  - CAPT at T+MAC_LAT=A+5, with mac_res_en in that cycle if mac_res_rdy=1.
  - out_valid from A+6.
- Replay: out_valid from A+2.
- Throughput: one new result per MAC_LAT+3 cycles; one replay per 2 cycles (with out_ready=1).
- A push and a pop in the same cycle are both honoured; count is unchanged.

## Configuration
- MAC_SEQ_WATCHDOG_EN defined:
  - 5-bit counter runs while in CAPT.
  - On the 16th consecutive cycle with mac_res_rdy=0, go to OUT with out_err=1 and out_data=0.
  - H is unchanged, and L is set to an impossible-match state so the next triple always issues.
- Undefined: CAPT waits indefinitely; out_err is tied to 0.

## Test plan
- Reset, push (0,0,0) at A → mac_en never asserts; out_valid at A+2 with out_data=0, out_idx=0.
- Push (3,5,7) at A → mac_en at A+2 with mac_m1=3, mac_m2=5, mac_addend=7; mac_res_en at A+5; out_data=22 at A+6.
- Push (2^64−1, 2^64−1, 2^64−1) → out_data=0xFFFFFFFFFFFFFFFF0000000000000000.
- Push (3,5,7), (3,5,7), (3,5,8) → outputs 22, 22, 23 with idx 0,1,2; exactly two mac_en pulses.
- Hold out_ready=0 and push 6 triples → in_ready drops once 4 entries are queued. Release out_ready → 6 results in order, idx consecutive. Also assert RST in WAIT → next cycle busy=0, out_valid=0, no mac_res_en.
- With MAC_SEQ_WATCHDOG_EN, hold mac_res_rdy=0 after an issue → out_err=1, out_data=0 on the 16th CAPT cycle. Without the macro, the FSM stays in CAPT.
